// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel-word FIFO.
package vga_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned DEPTH_DEF  = 64;
    localparam int unsigned LOW_WM_DEF = 16;
    localparam int unsigned UFL_CNT_W  = 16;

    typedef logic [WORD_W-1:0] word_t;

    // Word shown to the timing block when nothing is queued: all pixels lit.
    localparam word_t BLANK_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/vga_fifo_mem.sv
// DEPTH x 32 pixel-word storage: synchronous write, asynchronous read.
module vga_fifo_mem
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  word_t         wr_data,
    input  logic [AW-1:0] rd_addr,
    output word_t         rd_data
);

    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vga_word_fifo.sv
// Show-ahead pixel-word FIFO between the CPU and the VGA timing block.
// Optional VGA_FIFO_UFL_COUNT_EN adds a saturating underflow-pop counter (ufl_cnt).
module vga_word_fifo
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned LOW_WM = LOW_WM_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [31:0]               wr_data,
    input  logic                      req,
    input  logic                      rstart,
    input  logic                      ufl_clr,
    output logic [31:0]               data2,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      low_irq,
    output logic                      underflow
`ifdef VGA_FIFO_UFL_COUNT_EN
    ,
    output logic [UFL_CNT_W-1:0]      ufl_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] wr_ptr_nxt, rd_ptr_nxt;
    logic [AW:0]   level_nxt;
    logic          rstart_q;
    logic          rise_q;
    logic          flush_c;
    logic          pop_c;
    logic          push_c;
    logic          ufl_pop_c;
    word_t         rd_word;

    // Pointer/level next-state; a flush cycle swallows any push or pop.
    always_comb begin
        flush_c    = rise_q;
        ufl_pop_c  = req & empty;
        pop_c      = req & ~empty & ~flush_c;
        push_c     = wr_en & (~full | pop_c) & ~flush_c;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        level_nxt  = level;
        if (flush_c) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            level_nxt  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_nxt = wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_nxt = rd_ptr + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   level_nxt = level + (AW+1)'(1);
                2'b01:   level_nxt = level - (AW+1)'(1);
                default: level_nxt = level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            underflow <= 1'b0;
            low_irq   <= 1'b0;
            rstart_q  <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            level     <= level_nxt;
            empty     <= (level_nxt == '0);
            full      <= (level_nxt == (AW+1)'(DEPTH));
            underflow <= ufl_pop_c | (underflow & ~ufl_clr);
            low_irq   <= (level < (AW+1)'(LOW_WM));
            rstart_q  <= rstart;
            rise_q    <= rstart & ~rstart_q;
        end
    end

`ifdef VGA_FIFO_UFL_COUNT_EN
    // A clear in the same cycle as an underflow pop restarts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ufl_cnt <= '0;
        end else if (ufl_clr) begin
            ufl_cnt <= ufl_pop_c ? UFL_CNT_W'(1) : '0;
        end else if (ufl_pop_c && (ufl_cnt != '1)) begin
            ufl_cnt <= ufl_cnt + UFL_CNT_W'(1);
        end
    end
`endif

    vga_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_c),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    assign data2 = empty ? BLANK_WORD : rd_word;

endmodule
